// File: rtl/alu_pkg.sv
// Shared definitions for the uart_alu packet path: opcodes, header size, parser states.
package alu_pkg;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD32 = 8'hAD;
    localparam logic [7:0] OP_MUL32 = 8'h88;
    localparam logic [7:0] OP_DIV32 = 8'hD1;

    localparam int HDR_BYTES = 4;

    // The first HDR_BYTES encodings are the header-byte states, in arrival order.
    typedef enum logic [2:0] {
        OPCODE  = 3'd0,
        RSVD    = 3'd1,
        LEN_LSB = 3'd2,
        LEN_MSB = 3'd3,
        HDR     = 3'd4,
        PAYLOAD = 3'd5,
        DROP    = 3'd6
    } pkt_state_e;

    function automatic logic is_known_opcode(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_ADD32) || (op == OP_MUL32) || (op == OP_DIV32);
    endfunction

    function automatic logic is_hdr_state(input pkt_state_e s);
        return int'(s) < HDR_BYTES;
    endfunction

endpackage

// File: rtl/alu_pkt_timeout.sv
// Idle-cycle counter for the packet parser: counts enabled cycles, clears on request,
// and pulses expire_o (clearing itself) on the cycle the count sits at TimeoutCycles-1.
module alu_pkt_timeout #(
    parameter int TimeoutCycles = 8192
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] Terminal = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == Terminal);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_pkt_parser.sv
// Header/payload parser between the UART receiver and the ALU datapath.
// Build option PARSER_TIMEOUT_EN adds an idle-timeout abort (alu_pkt_timeout).
//
// state   | meaning
// OPCODE  | idle, next byte is an opcode
// RSVD    | reserved header byte, discarded
// LEN_LSB | length low byte
// LEN_MSB | length high byte, loads remaining-byte counter
// HDR     | presenting opcode/length to the ALU, receiver stalled
// PAYLOAD | payload bytes passed straight through to the ALU
// DROP    | payload of an unknown-opcode packet, swallowed
module alu_pkt_parser
    import alu_pkg::*;
#(
    parameter int TimeoutCycles = 8192
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        hdr_valid_o,
    input  logic        hdr_ready_i,
    output logic [7:0]  opcode_o,
    output logic [15:0] length_o,
    output logic [7:0]  pl_data_o,
    output logic        pl_valid_o,
    input  logic        pl_ready_i,
    output logic        pl_last_o,
    output logic        err_opcode_o,
    output logic        err_timeout_o,
    output logic        busy_o
);

    pkt_state_e  state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] length_q, length_d;
    logic [15:0] cnt_q, cnt_d;
    logic        bad_q, bad_d;
    logic        err_opcode_q, err_opcode_d;
    logic        err_timeout_q;
    logic        accept;
    logic        timeout_expire;

    always_comb begin
        rx_ready_o = 1'b0;
        if (is_hdr_state(state_q) || state_q == DROP) begin
            rx_ready_o = 1'b1;
        end else if (state_q == PAYLOAD) begin
            rx_ready_o = pl_ready_i;
        end
    end

    assign accept        = rx_valid_i && rx_ready_o;
    assign hdr_valid_o   = (state_q == HDR);
    assign pl_valid_o    = (state_q == PAYLOAD) && rx_valid_i;
    assign pl_data_o     = rx_data_i;
    assign pl_last_o     = (state_q == PAYLOAD) && (cnt_q == 16'd1);
    assign busy_o        = (state_q != OPCODE);
    assign opcode_o      = opcode_q;
    assign length_o      = length_q;
    assign err_opcode_o  = err_opcode_q;
    assign err_timeout_o = err_timeout_q;

`ifdef PARSER_TIMEOUT_EN
    logic idle_en;
    logic idle_clr;

    assign idle_en  = (state_q != OPCODE) && (state_q != HDR) && rx_ready_o && !rx_valid_i;
    assign idle_clr = accept || (state_d != state_q);

    alu_pkt_timeout #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (idle_clr),
        .en_i     (idle_en),
        .expire_o (timeout_expire)
    );
`else
    // Without the idle timer the parameter has no effect; this keeps it referenced.
    assign timeout_expire = (TimeoutCycles < 0);
`endif

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        length_d     = length_q;
        cnt_d        = cnt_q;
        bad_d        = bad_q;
        err_opcode_d = 1'b0;
        case (state_q)
            OPCODE: if (accept) begin
                opcode_d     = rx_data_i;
                bad_d        = !is_known_opcode(rx_data_i);
                err_opcode_d = !is_known_opcode(rx_data_i);
                state_d      = RSVD;
            end
            RSVD: if (accept) begin
                state_d = LEN_LSB;
            end
            LEN_LSB: if (accept) begin
                length_d[7:0] = rx_data_i;
                state_d       = LEN_MSB;
            end
            LEN_MSB: if (accept) begin
                length_d[15:8] = rx_data_i;
                cnt_d          = {rx_data_i, length_q[7:0]};
                if (!bad_q) begin
                    state_d = HDR;
                end else if (cnt_d == 16'd0) begin
                    state_d = OPCODE;
                end else begin
                    state_d = DROP;
                end
            end
            HDR: if (hdr_ready_i) begin
                state_d = (length_q != 16'd0) ? PAYLOAD : OPCODE;
            end
            PAYLOAD, DROP: if (accept) begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = OPCODE;
                end
            end
            default: state_d = OPCODE;
        endcase
        if (timeout_expire) begin
            state_d = OPCODE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= OPCODE;
            opcode_q      <= 8'h00;
            length_q      <= 16'h0000;
            cnt_q         <= 16'h0000;
            bad_q         <= 1'b0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            length_q      <= length_d;
            cnt_q         <= cnt_d;
            bad_q         <= bad_d;
            err_opcode_q  <= err_opcode_d;
            err_timeout_q <= timeout_expire;
        end
    end

endmodule

// File: tb/tb_alu_pkt_parser.sv
// Bench for alu_pkt_parser: directed packets plus randomized traffic against a packet-level model.
module tb_alu_pkt_parser;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        hdr_valid_o;
    logic        hdr_ready_i;
    logic [7:0]  opcode_o;
    logic [15:0] length_o;
    logic [7:0]  pl_data_o;
    logic        pl_valid_o;
    logic        pl_ready_i;
    logic        pl_last_o;
    logic        err_opcode_o;
    logic        err_timeout_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    int n_err_op = 0;
    int n_err_to = 0;
    int exp_op   = 0;
    int exp_to   = 0;

    logic [23:0] exp_hdr[$];
    logic [8:0]  exp_pl[$];
    logic [7:0]  pl_buf[16];
    logic [7:0]  valid_ops[4];

    alu_pkt_parser #(.TimeoutCycles(64)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .rx_ready_o    (rx_ready_o),
        .hdr_valid_o   (hdr_valid_o),
        .hdr_ready_i   (hdr_ready_i),
        .opcode_o      (opcode_o),
        .length_o      (length_o),
        .pl_data_o     (pl_data_o),
        .pl_valid_o    (pl_valid_o),
        .pl_ready_i    (pl_ready_i),
        .pl_last_o     (pl_last_o),
        .err_opcode_o  (err_opcode_o),
        .err_timeout_o (err_timeout_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_known(input logic [7:0] op);
        for (int i = 0; i < 4; i++) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // ALU-side ready pattern: 0 always, 1 header stalled, 2 payload ready toggles, 3 random
    initial begin
        hdr_ready_i = 1'b1;
        pl_ready_i  = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            case (mode)
                0: begin hdr_ready_i = 1'b1; pl_ready_i = 1'b1; end
                1: begin hdr_ready_i = 1'b0; pl_ready_i = 1'b1; end
                2: begin hdr_ready_i = 1'b1; pl_ready_i = ~pl_ready_i; end
                default: begin
                    hdr_ready_i = 1'($urandom_range(0, 1));
                    pl_ready_i  = 1'($urandom_range(0, 1));
                end
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (hdr_valid_o) chk("hdr_rx_ready", 32'(rx_ready_o), 0);
            if (hdr_valid_o && hdr_ready_i) begin
                if (exp_hdr.size() == 0) begin
                    chk("hdr_unexpected", 32'(exp_hdr.size()), 1);
                end else begin
                    logic [23:0] e;
                    e = exp_hdr.pop_front();
                    chk("hdr_opcode", 32'(opcode_o), 32'(e[23:16]));
                    chk("hdr_length", 32'(length_o), 32'(e[15:0]));
                end
            end
            if (pl_valid_o && pl_ready_i) begin
                if (exp_pl.size() == 0) begin
                    chk("pl_unexpected", 32'(exp_pl.size()), 1);
                end else begin
                    logic [8:0] p;
                    p = exp_pl.pop_front();
                    chk("pl_data", 32'(pl_data_o), 32'(p[7:0]));
                    chk("pl_last", 32'(pl_last_o), 32'(p[8]));
                end
            end
            if (err_opcode_o) n_err_op++;
            if (err_timeout_o) n_err_to++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int n;
        n = 0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk_i);
            #1;
        end
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        while (!rx_ready_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (!rx_ready_o) chk("rx_accept_wait", 32'(rx_ready_o), 1);
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    // Model: known opcode -> one header then the sent payload bytes, last on byte len-1;
    // unknown opcode -> one error pulse and nothing emitted.
    task automatic send_packet(input logic [7:0] op, input logic [15:0] len,
                               input int nsend, input int gap_max);
        if (is_known(op)) begin
            exp_hdr.push_back({op, len});
            for (int i = 0; i < nsend; i++) begin
                logic lst;
                lst = (i == int'(len) - 1);
                exp_pl.push_back({lst, pl_buf[i]});
            end
        end else begin
            exp_op++;
        end
        send_byte(op, gap_max);
        send_byte(8'($urandom), gap_max);
        send_byte(len[7:0], gap_max);
        send_byte(len[15:8], gap_max);
        for (int i = 0; i < nsend; i++) send_byte(pl_buf[i], gap_max);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_hdr.size() != 0 || exp_pl.size() != 0 || busy_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_hdr_left"}, 32'(exp_hdr.size()), 0);
        chk({tag, "_pl_left"}, 32'(exp_pl.size()), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready_o), 1);
        chk({tag, "_hdr_valid"}, 32'(hdr_valid_o), 0);
        chk({tag, "_pl_valid"}, 32'(pl_valid_o), 0);
        chk({tag, "_pl_last"}, 32'(pl_last_o), 0);
        chk({tag, "_err_op"}, 32'(err_opcode_o), 0);
        chk({tag, "_err_to"}, 32'(err_timeout_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_opcode"}, 32'(opcode_o), 0);
        chk({tag, "_length"}, 32'(length_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        valid_ops[0] = 8'hEC;
        valid_ops[1] = 8'hAD;
        valid_ops[2] = 8'h88;
        valid_ops[3] = 8'hD1;
        rst_i      = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_values("reset");
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        pl_buf[0] = 8'h41; pl_buf[1] = 8'h42; pl_buf[2] = 8'h43;
        send_packet(8'hEC, 16'd3, 3, 0);
        drain("echo");

        send_packet(8'hAD, 16'd0, 0, 0);
        drain("add_len0");

        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22;
        send_packet(8'h55, 16'd2, 2, 0);
        pl_buf[0] = 8'h7F;
        send_packet(8'hEC, 16'd1, 1, 0);
        drain("badop");
        chk("err_opcode_count", 32'(n_err_op), 32'(exp_op));

        // Header held off for 20 cycles with a payload byte already waiting upstream.
        mode = 1;
        @(posedge clk_i);
        #1;
        pl_buf[0] = 8'h31; pl_buf[1] = 8'h32; pl_buf[2] = 8'h33; pl_buf[3] = 8'h34;
        exp_hdr.push_back({8'hEC, 16'd4});
        for (int i = 0; i < 4; i++) exp_pl.push_back({(i == 3), pl_buf[i]});
        send_byte(8'hEC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        rx_data_i  = pl_buf[0];
        rx_valid_i = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            chk("hold_hdr_valid", 32'(hdr_valid_o), 1);
        end
        mode = 2;
        for (int i = 0; i < 4; i++) send_byte(pl_buf[i], 0);
        mode = 0;
        drain("stall");

        pl_buf[0] = 8'h01; pl_buf[1] = 8'h02;
        exp_hdr.push_back({8'hEC, 16'd5});
        exp_pl.push_back({1'b0, 8'h01});
        exp_pl.push_back({1'b0, 8'h02});
        send_byte(8'hEC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rst_i = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        pl_buf[0] = 8'h9A; pl_buf[1] = 8'hBC; pl_buf[2] = 8'hDE; pl_buf[3] = 8'hF0;
        send_packet(8'h88, 16'd4, 4, 0);
        drain("after_rst");

`ifdef PARSER_TIMEOUT_EN
        begin
            int n;
            pl_buf[0] = 8'hAA;
            send_packet(8'hEC, 16'd2, 1, 0);
            exp_to++;
            n = 0;
            while (n_err_to < exp_to && n < 100) begin
                @(negedge clk_i);
                n++;
            end
            chk("timeout_pulse", 32'(n_err_to), 32'(exp_to));
            drain("timeout");
            send_packet(8'hAD, 16'd0, 0, 0);
            drain("post_timeout");
        end
`endif

        mode = 3;
        for (int k = 0; k < 40; k++) begin
            logic [7:0]  op;
            logic [15:0] len;
            int r;
            r = int'($urandom_range(0, 9));
            op = (r < 8) ? valid_ops[r % 4] : 8'($urandom);
            len = 16'($urandom_range(0, 5));
            for (int i = 0; i < 16; i++) pl_buf[i] = 8'($urandom);
            send_packet(op, len, int'(len), 3);
        end
        mode = 0;
        drain("random");

        chk("err_opcode_total", 32'(n_err_op), 32'(exp_op));
        chk("err_timeout_total", 32'(n_err_to), 32'(exp_to));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
